pwm_peripheral: RTL

//   Downstream consumer of the SPI register block. Takes the output-enable, PWM-enable and duty-cycle

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_prescaler.sv | 34 +++
 rtl/pwm_peripheral.sv | 85 ++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared PWM widths, duty constants and the per-pin drive mux.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int              PWM_W     = 8;
    localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

    typedef logic [PWM_W-1:0] pwm_t;

    // Bitwise per-pin select: disabled -> 0, static -> 1, PWM -> shared waveform
    function automatic pwm_t pin_sel(input pwm_t en_out, input pwm_t en_pwm, input logic pwm);
        return en_out & (~en_pwm | {PWM_W{pwm}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Free-running divider; tick is high on the last cycle of every
//            CLK_DIV-cycle interval.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_prescaler #(
    parameter int CLK_DIV = 3000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(CLK_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    assign tick = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : pwm_peripheral
// Brief    : Drives 16 pins low, static high or from one shared 8-bit PWM.
//            Optional PWM_SHADOW_EN: duty is latched only at period wrap.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 3000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] en_out_uo,
    input  logic [7:0] en_out_uio,
    input  logic [7:0] en_pwm_uo,
    input  logic [7:0] en_pwm_uio,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       period_start
);

    logic w_tick;
    logic w_wrap;
    logic w_pwm_raw;
    pwm_t w_duty_act;
    pwm_t r_pwm_cnt;
    pwm_t r_uo;
    pwm_t r_uio;
    logic r_period_start;

    pwm_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_wrap = w_tick && (r_pwm_cnt == '1);

`ifdef PWM_SHADOW_EN
    pwm_t r_duty_act;

    // Loaded on the wrap edge so the new period starts with the new duty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_act <= '0;
        end else if (w_wrap) begin
            r_duty_act <= pwm_duty_cycle;
        end
    end

    assign w_duty_act = r_duty_act;
`else
    assign w_duty_act = pwm_duty_cycle;
`endif

    // Full-scale duty is pinned high rather than 255/256
    assign w_pwm_raw = (w_duty_act == DUTY_FULL) || (r_pwm_cnt < w_duty_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt      <= '0;
            r_uo           <= '0;
            r_uio          <= '0;
            r_period_start <= 1'b0;
        end else begin
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + pwm_t'(1);
            end
            r_period_start <= w_wrap;
            r_uo           <= pin_sel(en_out_uo,  en_pwm_uo,  w_pwm_raw);
            r_uio          <= pin_sel(en_out_uio, en_pwm_uio, w_pwm_raw);
        end
    end

    assign uo_out       = r_uo;
    assign uio_out      = r_uio;
    assign period_start = r_period_start;

endmodule
`default_nettype wire
